// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared definitions for the velocity ring consumer: fragment
//               layout constants, the unit state encoding and a per-axis
//               wrapping adder for packed {z,y,x} velocity words.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam int FRAG_W   = 97;  // {null, vz, vy, vx}
  localparam int NULL_BIT = 96;  // 1 -> fragment carries no data
  localparam int AXIS_W   = 32;  // per-axis two's complement width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Per-axis add of packed {z,y,x}; each lane wraps modulo 2**AXIS_W
  // independently so a carry never leaks into the neighbouring axis.
  function automatic logic [3*AXIS_W-1:0] add3(input logic [3*AXIS_W-1:0] a,
                                               input logic [3*AXIS_W-1:0] b);
    logic [3*AXIS_W-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[i*AXIS_W +: AXIS_W] = a[i*AXIS_W +: AXIS_W] + b[i*AXIS_W +: AXIS_W];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/velocity_accum_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : velocity_accum_unit_if
// Description : Drain stream from the velocity store to the position-update
//               stage (valid/ready).
// Ports       : v_out       drained velocity {z,y,x}
//               v_out_addr  particle address of v_out
//               v_out_valid v_out/v_out_addr valid
//               v_out_ready downstream accepts when valid & ready
// Revision    : 1.0 - initial release
// ============================================================================
interface velocity_accum_unit_if #(
  parameter int ADDR_W = 9,
  parameter int AXIS_W = 32
);
  logic [3*AXIS_W-1:0] v_out;
  logic [ADDR_W-1:0]   v_out_addr;
  logic                v_out_valid;
  logic                v_out_ready;

  modport master (output v_out, output v_out_addr, output v_out_valid, input v_out_ready);
  modport slave  (input v_out, input v_out_addr, input v_out_valid, output v_out_ready);
endinterface
`default_nettype wire

// File: rtl/vel_store_sdp.sv
`default_nettype none
// ============================================================================
// Module      : vel_store_sdp
// Description : Simple dual-port velocity store, one write port and one
//               synchronous read-first read port (a same-address read/write
//               on one edge returns the old contents). Not reset.
// Ports       : clk          clock
//               we/waddr/wdata  write port
//               raddr/rdata  read port, rdata valid one edge after raddr
// Revision    : 1.0 - initial release
// ============================================================================
module vel_store_sdp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 96,
  parameter int DEPTH  = 512
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output      logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/velocity_accum_unit.sv
`default_nettype none
// ============================================================================
// Module      : velocity_accum_unit
// Description : Accumulates non-null ring fragments per axis into a local
//               per-particle velocity store, then drains the store in
//               address order over a valid/ready stream.
// Ports       : clk, reset (sync, active-high)
//               frag_in/frag_addr   fragment from ring node, bit96 = null
//               load_en/addr/data   initial-velocity load (IDLE only)
//               accum_start         IDLE  -> ACCUM
//               drain_start         ACCUM -> FLUSH
//               v_if (master)       drain stream
//               drain_done          pulse after last entry accepted
//               state_o             current state
//               drop_err            sticky, data fragment outside ACCUM
// Revision    : 1.0 - initial release
// ============================================================================
module velocity_accum_unit #(
  parameter int ADDR_W = 9,
  parameter int AXIS_W = 32,
  parameter int DEPTH  = 512
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic [md_pkg::FRAG_W-1:0] frag_in,
  input  wire logic [ADDR_W-1:0]        frag_addr,
  input  wire logic                     load_en,
  input  wire logic [ADDR_W-1:0]        load_addr,
  input  wire logic [3*AXIS_W-1:0]      load_data,
  input  wire logic                     accum_start,
  input  wire logic                     drain_start,
  velocity_accum_unit_if.master         v_if,
  output      logic                     drain_done,
  output      logic [1:0]               state_o,
  output      logic                     drop_err
);
  import md_pkg::*;

  localparam int DW = 3*AXIS_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } ent_t;

  state_e            state_q, state_d;
  logic              s1_v_q, s1_v_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0]     s1_frag_q, s1_frag_d;
  logic              fwd_v_q, fwd_v_d;
  logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [DW-1:0]     fwd_val_q, fwd_val_d;
  logic              drop_err_q, drop_err_d;
  logic              drain_done_q, drain_done_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_all_q, rd_all_d;     // every address has been issued
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;   // address of the in-flight read
  logic              inflight_q, inflight_d;
  logic [1:0]        cnt_q, cnt_d;           // skid buffer occupancy
  ent_t              buf0_q, buf0_d;         // head, drives v_out
  ent_t              buf1_q, buf1_d;

  logic              st_we;
  logic [ADDR_W-1:0] st_waddr, st_raddr;
  logic [DW-1:0]     st_wdata, st_rdata;
  logic [DW-1:0]     operand, sum;
  logic              frag_data, pop, issue;
  logic [2:0]        occ;

  vel_store_sdp #(.ADDR_W(ADDR_W), .DATA_W(DW), .DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

  // Accumulate pipe: E0 samples + reads, S1 adds, E1 writes back.
  always_comb begin
    frag_data  = ~frag_in[NULL_BIT];
    s1_v_d     = frag_data && (state_q == ACCUM);
    s1_addr_d  = frag_addr;
    s1_frag_d  = frag_in[DW-1:0];
    drop_err_d = drop_err_q | (frag_data && (state_q != ACCUM));

    // The store is read-first, so the read issued on the write edge of the
    // previous same-address fragment is stale; take the forwarded sum.
    operand    = (fwd_v_q && (fwd_addr_q == s1_addr_q)) ? fwd_val_q : st_rdata;
    sum        = add3(operand, s1_frag_q);
    fwd_v_d    = s1_v_q;
    fwd_addr_d = s1_addr_q;
    fwd_val_d  = sum;

    st_we    = 1'b0;
    st_waddr = s1_addr_q;
    st_wdata = sum;
    if (s1_v_q) begin
      st_we = 1'b1;
    end else if (load_en && (state_q == IDLE)) begin
      st_we    = 1'b1;
      st_waddr = load_addr;
      st_wdata = load_data;
    end
    st_raddr = (state_q == DRAIN) ? rd_ptr_q : frag_addr;
  end

  // State machine, drain pointer and 2-entry output skid buffer.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    rd_all_d     = rd_all_q;
    rd_addr_d    = rd_addr_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    cnt_d        = cnt_q;

    pop = (cnt_q != 2'd0) && v_if.v_out_ready;
    // Slots committed after this edge; counting the pop keeps the stream
    // gapless at one entry per cycle when ready stays high.
    occ   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue = (state_q == DRAIN) && !rd_all_q && (occ < 3'd2);
    inflight_d = issue;

    if (issue) begin
      rd_addr_d = rd_ptr_q;
      rd_ptr_d  = rd_ptr_q + 1'b1;
      if (rd_ptr_q == LAST_ADDR) begin
        rd_all_d = 1'b1;
      end
    end

    if (pop) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (inflight_q) begin
      if ((cnt_q - {1'b0, pop}) == 2'd0) begin
        buf0_d = '{addr: rd_addr_q, data: st_rdata};
      end else begin
        buf1_d = '{addr: rd_addr_q, data: st_rdata};
      end
      cnt_d = cnt_d + 2'd1;
    end

    case (state_q)
      IDLE:  if (accum_start) state_d = ACCUM;
      ACCUM: if (drain_start) state_d = FLUSH;
      FLUSH: begin
        if (!s1_v_q && !fwd_v_q) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
          rd_all_d = 1'b0;
        end
      end
      DRAIN: begin
        if (pop && (buf0_q.addr == LAST_ADDR)) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_v_q       <= 1'b0;
      s1_addr_q    <= '0;
      s1_frag_q    <= '0;
      fwd_v_q      <= 1'b0;
      fwd_addr_q   <= '0;
      fwd_val_q    <= '0;
      drop_err_q   <= 1'b0;
      drain_done_q <= 1'b0;
      rd_ptr_q     <= '0;
      rd_all_q     <= 1'b0;
      rd_addr_q    <= '0;
      inflight_q   <= 1'b0;
      cnt_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      s1_v_q       <= s1_v_d;
      s1_addr_q    <= s1_addr_d;
      s1_frag_q    <= s1_frag_d;
      fwd_v_q      <= fwd_v_d;
      fwd_addr_q   <= fwd_addr_d;
      fwd_val_q    <= fwd_val_d;
      drop_err_q   <= drop_err_d;
      drain_done_q <= drain_done_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_all_q     <= rd_all_d;
      rd_addr_q    <= rd_addr_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  assign v_if.v_out       = buf0_q.data;
  assign v_if.v_out_addr  = buf0_q.addr;
  assign v_if.v_out_valid = (cnt_q != 2'd0);
  assign drain_done       = drain_done_q;
  assign state_o          = state_q;
  assign drop_err         = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_velocity_accum_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_velocity_accum_unit
// Description : Randomized bench for velocity_accum_unit. A per-axis array
//               model tracks the expected store; each drain pushes the whole
//               expected store into a queue that a negedge monitor consumes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_velocity_accum_unit;

  localparam int ADDR_W = 9;
  localparam int AXIS_W = 32;
  localparam int DEPTH  = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [96:0] frag_in;
  logic [8:0]  frag_addr;
  logic        load_en;
  logic [8:0]  load_addr;
  logic [95:0] load_data;
  logic        accum_start;
  logic        drain_start;
  logic        drain_done;
  logic [1:0]  state_o;
  logic        drop_err;

  always #5 clk = ~clk;

  velocity_accum_unit_if #(.ADDR_W(ADDR_W), .AXIS_W(AXIS_W)) vif ();

  velocity_accum_unit #(.ADDR_W(ADDR_W), .AXIS_W(AXIS_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .frag_in     (frag_in),
    .frag_addr   (frag_addr),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .accum_start (accum_start),
    .drain_start (drain_start),
    .v_if        (vif),
    .drain_done  (drain_done),
    .state_o     (state_o),
    .drop_err    (drop_err)
  );

  // Reference model: one velocity per particle per axis.
  logic [31:0] mx [DEPTH];
  logic [31:0] my [DEPTH];
  logic [31:0] mz [DEPTH];

  typedef struct {
    logic [8:0]  addr;
    logic [95:0] data;
  } exp_t;
  exp_t exp_q[$];

  int     vec_cnt = 0;
  int     err_cnt = 0;
  bit     mon_en = 1'b0;
  bit     rdy_rand = 1'b0;
  bit     done_seen = 1'b0;
  int     done_cnt = 0;
  int     acc_cnt = 0;
  longint cyc = 0;
  longint first_acc = 0;
  longint last_acc = 0;
  bit     held_v = 1'b0;
  logic [8:0]  held_a;
  logic [95:0] held_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_null();
    frag_in   = {1'b1, 32'($urandom()), 32'($urandom()), 32'($urandom())};
    frag_addr = 9'($urandom());
  endtask

  task automatic load(input int a, input logic [31:0] z, input logic [31:0] y, input logic [31:0] x);
    load_en   = 1'b1;
    load_addr = 9'(a);
    load_data = {z, y, x};
    mx[a] = x; my[a] = y; mz[a] = z;
    tick();
    load_en = 1'b0;
  endtask

  task automatic prep_drain(input bit rnd);
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back('{addr: 9'(a), data: {mz[a], my[a], mx[a]}});
    end
    acc_cnt   = 0;
    done_cnt  = 0;
    done_seen = 1'b0;
    held_v    = 1'b0;
    rdy_rand  = rnd;
    mon_en    = 1'b1;
  endtask

  task automatic send(input int a, input logic [31:0] z, input logic [31:0] y,
                      input logic [31:0] x, input bit with_drain, input bit rnd);
    mx[a] = mx[a] + x; my[a] = my[a] + y; mz[a] = mz[a] + z;
    if (with_drain) prep_drain(rnd);
    frag_in     = {1'b0, z, y, x};
    frag_addr   = 9'(a);
    drain_start = with_drain;
    tick();
    drain_start = 1'b0;
    idle_null();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && !done_seen; i++) tick();
    if (!done_seen) chk("drain_timeout", 128'(done_seen), 128'(1));
    repeat (3) tick();
    chk("done_pulses", 128'(done_cnt), 128'(1));
    chk("accept_count", 128'(acc_cnt), 128'(DEPTH));
    chk("state_after_drain", 128'(state_o), 128'(0));
    chk("valid_after_drain", 128'(vif.v_out_valid), 128'(0));
    mon_en = 1'b0;
  endtask

  // Ready driver
  initial begin
    vif.v_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vif.v_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (vif.v_out_valid) begin
        if (held_v) chk("stall_hold", {vif.v_out_addr, vif.v_out}, {held_a, held_d});
        if (vif.v_out_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            chk("out_expected", 128'(exp_q.size()), 128'(1));
          end else begin
            e = exp_q.pop_front();
            chk("drain_addr", 128'(vif.v_out_addr), 128'(e.addr));
            chk("drain_data", 128'(vif.v_out), 128'(e.data));
          end
          acc_cnt++;
          if (acc_cnt == 1) first_acc = cyc;
          last_acc = cyc;
        end else begin
          held_v = 1'b1;
          held_a = vif.v_out_addr;
          held_d = vif.v_out;
        end
      end
      if (drain_done) begin
        done_cnt++;
        done_seen = 1'b1;
        chk("done_state", 128'(state_o), 128'(0));
        chk("done_valid", 128'(vif.v_out_valid), 128'(0));
        chk("done_queue_empty", 128'(exp_q.size()), 128'(0));
      end
    end
  end

  initial begin
    load_en = 1'b0; load_addr = '0; load_data = '0;
    accum_start = 1'b0; drain_start = 1'b0;
    idle_null();
    repeat (3) tick();
    chk("rst_state", 128'(state_o), 128'(0));
    chk("rst_valid", 128'(vif.v_out_valid), 128'(0));
    chk("rst_vout", 128'(vif.v_out), 128'(0));
    chk("rst_vaddr", 128'(vif.v_out_addr), 128'(0));
    chk("rst_done", 128'(drain_done), 128'(0));
    chk("rst_drop", 128'(drop_err), 128'(0));
    reset = 1'b0;
    tick();

    // Round 1: load, directed + random accumulation, random-ready drain
    for (int a = 0; a < DEPTH; a++) load(a, $urandom(), $urandom(), $urandom());
    load(5, 32'd0, 32'd0, 32'd10);
    load(9, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    accum_start = 1'b1; tick(); accum_start = 1'b0;
    chk("state_accum", 128'(state_o), 128'(1));
    send(5, 0, 0, 3, 0, 0);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) send(7, 0, 0, 1, 0, 0);
    repeat (2) tick();
    send(7, 0, 0, 1, 0, 0);
    send(8, 0, 0, 1, 0, 0);
    send(7, 0, 0, 1, 0, 0);
    tick();
    send(9, 0, 32'hFFFF_FFFF, 1, 0, 0);
    // Loads are ignored outside IDLE; model untouched
    load_en = 1'b1; load_addr = 9'd3; load_data = {3{32'hDEAD_BEEF}};
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int a;
      a = (i % 8 == 7) ? int'($urandom_range(16, DEPTH-1)) : int'($urandom_range(16, 31));
      send(a, $urandom(), $urandom(), $urandom(), 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end
    send(12, $urandom(), $urandom(), $urandom(), 1, 1);
    chk("state_flush", 128'(state_o), 128'(2));
    wait_drain();
    chk("drop_clear_r1", 128'(drop_err), 128'(0));

    // Round 2: dropped fragment in IDLE, gapless drain with ready high
    frag_in = {1'b0, 32'd0, 32'd0, 32'd100}; frag_addr = 9'd5;
    tick();
    idle_null();
    tick();
    chk("drop_err_set", 128'(drop_err), 128'(1));
    accum_start = 1'b1; tick(); accum_start = 1'b0;
    repeat (3) tick();
    prep_drain(1'b0);
    drain_start = 1'b1; tick(); drain_start = 1'b0;
    wait_drain();
    chk("no_gaps", 128'(last_acc - first_acc), 128'(DEPTH - 1));
    chk("drop_err_sticky", 128'(drop_err), 128'(1));

    // Round 3: reset in the middle of a drain
    accum_start = 1'b1; tick(); accum_start = 1'b0;
    prep_drain(1'b1);
    drain_start = 1'b1; tick(); drain_start = 1'b0;
    for (int i = 0; i < 500 && acc_cnt < 20; i++) tick();
    chk("mid_drain_progress", 128'(acc_cnt >= 20), 128'(1));
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_valid", 128'(vif.v_out_valid), 128'(0));
    chk("abort_state", 128'(state_o), 128'(0));
    chk("abort_drop", 128'(drop_err), 128'(0));
    chk("abort_done", 128'(drain_done), 128'(0));
    exp_q.delete();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
